csa3_resolver: RTL and testbench

Sequential carry-propagate back end for the multiplier's 5:3 compression stage. Takes the three 64-bit rows the compressor emits (weights 1, 2 and 4) and resolves them into one binary product word. Uses a carry-save pre-step and a chunked ripple adder over several cycles. Sits between the final compression level and the product register, with valid/ready handshakes on both sides.

---
 rtl/csa3_resolver.sv | 120 ++++++++++++
 tb/tb_csa3_resolver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/csa3_resolver.sv
// Resolves three weighted partial-product rows (x1, x2, x4) into one binary word:
// a single 3:2 carry-save level, then a chunked ripple add over NCHUNK cycles.
module csa3_resolver #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] S1,
    input  logic [WIDTH-1:0] S2,
    input  logic [WIDTH-1:0] S3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSA  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_c;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_p;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [CHUNK-1:0]  w_xc;
    logic [CHUNK-1:0]  w_yc;
    logic [CHUNK:0]    w_sum;
    logic              w_accept;
    logic              w_last;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign P         = r_p;
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_idx == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_CSA;
            ST_CSA:                 w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Chunk select by decode keeps every part-select index constant.
    always_comb begin
        w_xc = '0;
        w_yc = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_xc = r_x[k*CHUNK +: CHUNK];
                w_yc = r_y[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_sum = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_p     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a <= S1;
                        r_b <= S2 << 1;
                        r_c <= S3 << 2;
                    end
                end
                ST_CSA: begin
                    r_x     <= r_a ^ r_b ^ r_c;
                    r_y     <= ((r_a & r_b) | (r_a & r_c) | (r_b & r_c)) << 1;
                    r_idx   <= '0;
                    r_carry <= 1'b0;
                end
                ST_ADD: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (r_idx == IDXW'(k)) r_p[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                    end
                    r_carry <= w_sum[CHUNK];
                    if (!w_last) r_idx <= r_idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa3_resolver.sv
// Scoreboard bench for csa3_resolver: directed carry/wrap/backpressure/reset cases
// followed by random row sets with random output stalls.
module tb_csa3_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] S1, S2, S3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accepts = 0;
    int          n_sent = 0;
    logic [63:0] sb[$];

    csa3_resolver #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .S1(S1), .S2(S2), .S3(S3),
        .out_valid(out_valid), .out_ready(out_ready),
        .P(P), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && in_valid && in_ready) n_accepts++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, b, c);
        return a + (b << 1) + (c << 2);
    endfunction

    // Drive one row set, check latency, optionally stall the output, then pop/compare.
    task automatic run_op(input logic [63:0] a, b, c, input int stall, input bit verbose);
        int n;
        logic [63:0] held;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        S1 = a; S2 = b; S3 = c; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, c));
        n_sent++;
        #1;
        in_valid = 1'b0;
        S1 = {$urandom, $urandom}; S2 = {$urandom, $urandom}; S3 = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'd5);
        if (verbose) check("busy_done", {63'd0, busy}, 64'd1);
        held = P;
        for (int i = 0; i < stall; i++) begin
            S1 = {$urandom, $urandom}; S2 = {$urandom, $urandom}; S3 = {$urandom, $urandom};
            in_valid = 1'(i & 1);
            @(posedge clk); #1;
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_P", P, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) check("sb_empty_pop", 64'd0, 64'd1);
        else check("P", P, sb.pop_front());
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
        check("out_valid_after", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        S1 = '0; S2 = '0; S3 = '0;
        #12;
        check("rst_P", P, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(64'd1, 64'd1, 64'd1, 0, 1);
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 64'd0, 0, 1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h8000_0000_0000_0001, 10, 1);

        // Idle with in_valid low: P must hold.
        repeat (3) @(posedge clk);
        #1 check("idle_hold_P", P, 64'h1234_5678_9ABC_DEF0 + (64'h0FED_CBA9_8765_4321 << 1)
                                    + (64'h8000_0000_0000_0001 << 2));

        // Abandon an operation during its second ADD cycle.
        S1 = 64'hDEAD_BEEF_0000_1111; S2 = 64'h77; S3 = 64'h3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_P", P, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        n_accepts = n_accepts - 1;
        @(posedge clk); #1;
        run_op(64'd5, 64'd0, 64'd0, 0, 1);

        for (int i = 0; i < 1000; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("accept_count", 64'(n_accepts), 64'(n_sent));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
